ewrapper_io_rx_align: RTL and testbench
=======================================

Name: ewrapper_io_rx_align

Overview:
- Fast-clock (rxi_lclk) frame-alignment gearbox for the eLink receive path.
- Sits directly downstream of the 9-lane IDDR capture, in parallel with the fixed-phase slow deserializer.
- Consumes one even/odd bit pair per lane per cycle and hunts for the frame-lane (lane 8) rising edge.
- Emits 72-bit words aligned so each frame start lands on a byte boundary, with valid and toggle strobes for the slow-clock capture.

Parameters:
- ERR_LIMIT, 1, consecutive illegal frame bytes in LOCKED before the FSM returns to HUNT (range 1..15).
- CNT_W, 8, width of the saturating alignment-error counter.

Ports:
- rxi_lclk  input  1  fast eLink receive clock.
- reset  input  1  reset, asynchronous, active-high.
- even_in  input  9  registered IDDR first-half bits, one per lane; bit 8 is the frame lane.
- odd_in  input  9  registered IDDR second-half bits, one per lane.
- force_hunt  input  1  synchronous pulse; forces HUNT and discards the current alignment.
- word_out  output  72  aligned word; lane k byte at [8k+7:8k], MSB is the earliest bit.
- word_valid  output  1  one-cycle pulse when word_out updates.
- word_toggle  output  1  inverts on every word_valid; used for the slow-domain CDC.
- aligned  output  1  high while in LOCKED.
- align_err  output  1  one-cycle pulse on each illegal frame byte in LOCKED.
- err_count  output  CNT_W  saturating count of align_err pulses.

Behaviour:
- Reset values: word_out=0, word_valid=0, word_toggle=0, aligned=0, align_err=0, err_count=0, state=HUNT, sr=0, phase=0, off=0.
- Per-lane shift register, 9 bits: every cycle sr <= {sr[6:0], even_in[k], odd_in[k]}. After each update, sr[0] is the newest odd bit and sr[1] the newest even bit.
- Rise detection runs on the lane-8 register after each update:
  - Even-rise: sr[2]=0 and sr[1]=1.
  - Odd-rise: sr[1]=0 and sr[0]=1.
- Extraction: byte = off ? sr[8:1] : sr[7:0].
- A 2-bit phase counter runs continuously. A word is extracted when phase == 3.
- HUNT state:
  - aligned=0, no word_valid.
  - Even-rise detected on the pair captured at edge n: load off=0 and preset phase so that extraction happens on the sr contents after edge n+3.
  - Odd-rise detected at edge n: load off=1 and extract after edge n+4.
  - On detection go to LOCKED.
- LOCKED state:
  - aligned=1.
  - At each extraction point, register all 9 lane bytes into word_out on the next edge. word_valid pulses one cycle and word_toggle inverts.
  - Latency: word_valid is high in the cycle after edge n+4 (even-rise) or edge n+5 (odd-rise). Every 4 cycles thereafter.
  - Frame-lane byte check at each extraction: 0x00 and 0xFF are legal; any other value is illegal.
  - Illegal byte: pulse align_err, increment err_count (saturate at 2^CNT_W-1), increment the consecutive-error counter.
  - Legal byte: clear the consecutive-error counter.
  - Consecutive-error counter reaches ERR_LIMIT: go to HUNT on the same edge. The offending word is still emitted with word_valid.
- force_hunt: in any state goes to HUNT on the next edge and suppresses word_valid and align_err for that edge. It has priority over a same-cycle illegal byte. It does not clear err_count.
- A frame rise seen in LOCKED is not re-detected; misalignment surfaces only through the illegal-byte check.
- Asynchronous reset mid-word: the partial word is discarded and the block restarts in HUNT.

Decomposition:
- Shared package (ewrapper constants): frame lane index (8), lane count (9), legal frame byte constants (0x00, 0xFF), FSM state encoding (HUNT, LOCKED).
- Sub-module ewrapper_rx_lane_sr: one 9-bit lane shift register plus the off-selected byte extractor, instantiated 9 times. Lane 8's raw sr also drives rise detection.

Test Plan:
- Reset, then idle lanes at 0 -> aligned=0, word_valid never asserts, all outputs 0.
- Even-rise: frame lane goes 0→1 on even_in at pair n and stays 1; lane 0 sends bits 1,0,1,0,0,1,0,1 from pair n -> word_valid at cycle n+5, word_out[71:64]=0xFF, word_out[7:0]=0xA5, aligned=1, word_toggle=1.
- Odd-rise: same data shifted by one half-bit (frame rises on odd_in) -> word_valid at cycle n+6, identical bytes, off=1.
- LOCKED with ERR_LIMIT=2: inject frame byte 0x3C once -> align_err pulse, err_count=1, stays LOCKED. Inject 0x3C twice in a row -> err_count=3, aligned=0 after the second.
- force_hunt in the same cycle as an illegal frame byte -> no align_err, err_count unchanged, aligned=0, no word_valid. The next frame rise relocks.
- Assert reset mid-word in LOCKED -> all outputs 0 immediately. After release, relock occurs on the next frame rise with correct latency.

Source files
------------

// File: rtl/ewrapper_io_rx_align_pkg.sv
// Shared eLink receive constants: lane geometry, legal frame-lane bytes and
// the alignment FSM encoding.
package ewrapper_io_rx_align_pkg;

  localparam int NUM_LANES  = 9;
  localparam int FRAME_LANE = 8;

  localparam logic [7:0] FRAME_IDLE = 8'h00;
  localparam logic [7:0] FRAME_BUSY = 8'hFF;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } rx_state_e;

  function automatic logic frame_byte_legal(input logic [7:0] b);
    return (b == FRAME_IDLE) || (b == FRAME_BUSY);
  endfunction

endpackage

// File: rtl/ewrapper_io_rx_align_lane_sr.sv
// One receive lane: 9-bit half-bit shift register and the offset-selected
// byte extractor. The newest three bits are exposed for edge detection.
module ewrapper_rx_lane_sr (
  input  logic       rxi_lclk,
  input  logic       reset,
  input  logic       even_i,
  input  logic       odd_i,
  input  logic       off_i,
  output logic [2:0] sr_tail_o,
  output logic [7:0] byte_o
);

  logic [8:0] sr_q;

  // Even bit lands one place above the odd bit, so sr[0] is always newest.
  always_ff @(posedge rxi_lclk or posedge reset) begin
    if (reset) sr_q <= '0;
    else       sr_q <= {sr_q[6:0], even_i, odd_i};
  end

  assign sr_tail_o = sr_q[2:0];
  assign byte_o    = off_i ? sr_q[8:1] : sr_q[7:0];

endmodule

// File: rtl/ewrapper_io_rx_align.sv
// Fast-clock frame-alignment gearbox: hunts for the frame-lane rising edge and
// emits byte-aligned 72-bit words with valid/toggle strobes for the slow domain.
module ewrapper_io_rx_align
  import ewrapper_io_rx_align_pkg::*;
#(
  parameter int ERR_LIMIT = 1,
  parameter int CNT_W     = 8
) (
  input  logic             rxi_lclk,
  input  logic             reset,
  input  logic [8:0]       even_in,
  input  logic [8:0]       odd_in,
  input  logic             force_hunt,
  output logic [71:0]      word_out,
  output logic             word_valid,
  output logic             word_toggle,
  output logic             aligned,
  output logic             align_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [3:0] ERR_LIMIT_W = 4'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rx_state_e        state_q;
  logic [1:0]       phase_q;
  logic             off_q;
  logic [3:0]       consec_q;
  logic [71:0]      word_q;
  logic             valid_q;
  logic             toggle_q;
  logic             aligned_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [71:0]      word_d;
  logic [2:0]       frame_tail;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [7:0] lane_byte;
    if (k == FRAME_LANE) begin : g_frame
      ewrapper_rx_lane_sr u_sr (
        .rxi_lclk  (rxi_lclk),
        .reset     (reset),
        .even_i    (even_in[k]),
        .odd_i     (odd_in[k]),
        .off_i     (off_q),
        .sr_tail_o (frame_tail),
        .byte_o    (lane_byte)
      );
    end else begin : g_data
      logic [2:0] unused_tail;
      ewrapper_rx_lane_sr u_sr (
        .rxi_lclk  (rxi_lclk),
        .reset     (reset),
        .even_i    (even_in[k]),
        .odd_i     (odd_in[k]),
        .off_i     (off_q),
        .sr_tail_o (unused_tail),
        .byte_o    (lane_byte)
      );
    end
    assign word_d[k*8 +: 8] = lane_byte;
  end

  logic       even_rise;
  logic       odd_rise;
  logic       frame_ok;
  logic [3:0] consec_inc;

  assign even_rise  = ~frame_tail[2] & frame_tail[1];
  assign odd_rise   = ~frame_tail[1] & frame_tail[0];
  assign frame_ok   = frame_byte_legal(word_d[FRAME_LANE*8 +: 8]);
  assign consec_inc = consec_q + 4'd1;

  always_ff @(posedge rxi_lclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HUNT;
      phase_q   <= 2'd0;
      off_q     <= 1'b0;
      consec_q  <= 4'd0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      toggle_q  <= 1'b0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      phase_q <= phase_q + 2'd1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (force_hunt) begin
        state_q   <= ST_HUNT;
        aligned_q <= 1'b0;
        consec_q  <= 4'd0;
      end else begin
        case (state_q)
          ST_HUNT: begin
            // Preset phase so phase==3 coincides with the full byte in sr.
            if (even_rise || odd_rise) begin
              state_q   <= ST_LOCKED;
              aligned_q <= 1'b1;
              off_q     <= odd_rise;
              phase_q   <= even_rise ? 2'd1 : 2'd0;
              consec_q  <= 4'd0;
            end
          end
          ST_LOCKED: begin
            if (phase_q == 2'd3) begin
              word_q   <= word_d;
              valid_q  <= 1'b1;
              toggle_q <= ~toggle_q;
              if (!frame_ok) begin
                err_q <= 1'b1;
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
                if (consec_inc >= ERR_LIMIT_W) begin
                  state_q   <= ST_HUNT;
                  aligned_q <= 1'b0;
                  consec_q  <= 4'd0;
                end else begin
                  consec_q <= consec_inc;
                end
              end else begin
                consec_q <= 4'd0;
              end
            end
          end
          default: begin
            state_q   <= ST_HUNT;
            aligned_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign word_out    = word_q;
  assign word_valid  = valid_q;
  assign word_toggle = toggle_q;
  assign aligned     = aligned_q;
  assign align_err   = err_q;
  assign err_count   = cnt_q;

endmodule

// File: tb/tb_ewrapper_io_rx_align.sv
// Directed bench for ewrapper_io_rx_align: half-bit streams per segment, expected
// words queued at stimulus time and checked by an independent monitor.
module tb_ewrapper_io_rx_align;

  logic        rxi_lclk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  even_in = '0;
  logic [8:0]  odd_in = '0;
  logic        force_hunt = 1'b0;
  logic [71:0] word_out;
  logic        word_valid;
  logic        word_toggle;
  logic        aligned;
  logic        align_err;
  logic [7:0]  err_count;

  always #5 rxi_lclk = ~rxi_lclk;

  ewrapper_io_rx_align #(.ERR_LIMIT(2), .CNT_W(8)) dut (
    .rxi_lclk    (rxi_lclk),
    .reset       (reset),
    .even_in     (even_in),
    .odd_in      (odd_in),
    .force_hunt  (force_hunt),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_toggle (word_toggle),
    .aligned     (aligned),
    .align_err   (align_err),
    .err_count   (err_count)
  );

  int cyc = 0;
  always @(posedge rxi_lclk) cyc <= cyc + 1;

  typedef struct {
    logic [71:0] word;
    int          seg;
    int          hlast;
    logic        err;
    logic [7:0]  cnt;
    logic        alg;
    logic        tog;
  } exp_t;

  exp_t sb[$];
  int   seg_base [16];
  int   seg_id = 0;
  bit   hf[$];
  bit   hd[$];
  bit   fh_mark [64];
  logic exp_tog = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every valid word must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge rxi_lclk);
      if (word_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_valid: got word %0h at cycle %0d expected no word", word_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("word", word_out, e.word);
          chk("valid_cycle", 72'(cyc), 72'(seg_base[e.seg] + 2 + e.hlast / 2));
          chk("toggle", 72'(word_toggle), 72'(e.tog));
          chk("align_err", 72'(align_err), 72'(e.err));
          chk("err_count", 72'(err_count), 72'(e.cnt));
          chk("aligned", 72'(aligned), 72'(e.alg));
        end
      end else if (align_err === 1'b1) begin
        n_total++;
        $display("FAIL stray_align_err: got 1 at cycle %0d expected 0", cyc);
      end
    end
  end

  task automatic new_seg();
    seg_id++;
    hf.delete();
    hd.delete();
    foreach (fh_mark[i]) fh_mark[i] = 1'b0;
  endtask

  task automatic add_half(input bit f, input bit d);
    hf.push_back(f);
    hd.push_back(d);
  endtask

  task automatic add_idle(input int halves);
    for (int i = 0; i < halves; i++) add_half(1'b0, 1'b0);
  endtask

  task automatic add_byte(input logic [7:0] fb, input logic [7:0] db);
    for (int i = 7; i >= 0; i--) add_half(fb[i], db[i]);
  endtask

  task automatic expect_word(input logic [7:0] fb, input logic [7:0] db,
                             input logic err, input logic [7:0] cnt, input logic alg);
    exp_t e;
    exp_tog = ~exp_tog;
    e.word  = {fb, 56'h0, db};
    e.seg   = seg_id;
    e.hlast = hf.size() - 1;
    e.err   = err;
    e.cnt   = cnt;
    e.alg   = alg;
    e.tog   = exp_tog;
    sb.push_back(e);
  endtask

  // Pulse force_hunt on the edge that would register the byte just added.
  task automatic hunt_at_extract();
    int p;
    p = (hf.size() - 1) / 2 + 1;
    fh_mark[p] = 1'b1;
    while (hf.size() < 2 * (p + 1)) add_half(1'b0, 1'b0);
  endtask

  task automatic play();
    if (hf.size() % 2 != 0) add_half(1'b0, 1'b0);
    for (int p = 0; p < hf.size() / 2; p++) begin
      @(negedge rxi_lclk);
      if (p == 0) seg_base[seg_id] = cyc;
      even_in    = {hf[2*p],   7'b0, hd[2*p]};
      odd_in     = {hf[2*p+1], 7'b0, hd[2*p+1]};
      force_hunt = fh_mark[p];
    end
    @(negedge rxi_lclk);
    even_in    = '0;
    odd_in     = '0;
    force_hunt = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_word_out"}, word_out, 72'h0);
    chk({tag, "_word_valid"}, 72'(word_valid), 72'h0);
    chk({tag, "_word_toggle"}, 72'(word_toggle), 72'h0);
    chk({tag, "_aligned"}, 72'(aligned), 72'h0);
    chk({tag, "_align_err"}, 72'(align_err), 72'h0);
    chk({tag, "_err_count"}, 72'(err_count), 72'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(negedge rxi_lclk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Idle lanes: nothing should lock or emit.
    repeat (10) @(negedge rxi_lclk);
    chk("idle_aligned", 72'(aligned), 72'h0);
    chk("idle_err_count", 72'(err_count), 72'h0);

    // Even-rise lock.
    new_seg();
    add_idle(8);
    add_byte(8'hFF, 8'hA5); expect_word(8'hFF, 8'hA5, 1'b0, 8'd0, 1'b1);
    add_byte(8'hFF, 8'h5A); expect_word(8'hFF, 8'h5A, 1'b0, 8'd0, 1'b1);
    add_byte(8'h00, 8'h00); hunt_at_extract();
    play();

    // Odd-rise lock (offset by one half-bit).
    new_seg();
    add_idle(7);
    add_byte(8'hFF, 8'hA5); expect_word(8'hFF, 8'hA5, 1'b0, 8'd0, 1'b1);
    add_byte(8'h00, 8'hC3); expect_word(8'h00, 8'hC3, 1'b0, 8'd0, 1'b1);
    add_byte(8'h00, 8'h00); hunt_at_extract();
    play();

    // Illegal frame bytes with ERR_LIMIT=2.
    new_seg();
    add_idle(8);
    add_byte(8'hFF, 8'h11); expect_word(8'hFF, 8'h11, 1'b0, 8'd0, 1'b1);
    add_byte(8'h3C, 8'h22); expect_word(8'h3C, 8'h22, 1'b1, 8'd1, 1'b1);
    add_byte(8'hFF, 8'h33); expect_word(8'hFF, 8'h33, 1'b0, 8'd1, 1'b1);
    add_byte(8'h3C, 8'h44); expect_word(8'h3C, 8'h44, 1'b1, 8'd2, 1'b1);
    add_byte(8'h3C, 8'h55); expect_word(8'h3C, 8'h55, 1'b1, 8'd3, 1'b0);
    add_idle(4);
    play();

    // force_hunt on the same edge as an illegal byte.
    new_seg();
    add_idle(8);
    add_byte(8'hFF, 8'h66); expect_word(8'hFF, 8'h66, 1'b0, 8'd3, 1'b1);
    add_byte(8'h3C, 8'h77); hunt_at_extract();
    play();
    repeat (2) @(negedge rxi_lclk);
    chk("fh_aligned", 72'(aligned), 72'h0);
    chk("fh_err_count", 72'(err_count), 72'd3);

    // Relock after force_hunt.
    new_seg();
    add_idle(8);
    add_byte(8'hFF, 8'h88); expect_word(8'hFF, 8'h88, 1'b0, 8'd3, 1'b1);
    add_byte(8'h00, 8'h00); hunt_at_extract();
    play();

    // Reset mid-word while locked.
    new_seg();
    add_idle(8);
    add_byte(8'hFF, 8'h99); expect_word(8'hFF, 8'h99, 1'b0, 8'd3, 1'b1);
    add_half(1'b0, 1'b1); add_half(1'b0, 1'b1); add_half(1'b0, 1'b1); add_half(1'b0, 1'b1);
    play();
    @(posedge rxi_lclk);
    chk("pre_reset_aligned", 72'(aligned), 72'h1);
    chk("sb_drained_before_reset", 72'(sb.size()), 72'h0);
    #3 reset = 1'b1;
    #1 chk_all_zero("midword_reset");
    exp_tog = 1'b0;
    repeat (2) @(negedge rxi_lclk);
    reset = 1'b0;

    // Relock after reset with nominal latency and cleared counters.
    new_seg();
    add_idle(8);
    add_byte(8'hFF, 8'hA5); expect_word(8'hFF, 8'hA5, 1'b0, 8'd0, 1'b1);
    add_byte(8'h00, 8'h00); hunt_at_extract();
    play();

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge rxi_lclk);
    repeat (4) @(negedge rxi_lclk);
    chk("sb_drained_at_end", 72'(sb.size()), 72'h0);
    chk("final_aligned", 72'(aligned), 72'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
